slave_ocp: RTL and testbench

//  OCP target that sits directly downstream of the OCP master on the shared bus.

---
 rtl/slave_ocp_if.sv | 26 ++
 rtl/slave_ocp.sv | 202 ++++++++++++++++++++
 tb/tb_slave_ocp.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slave_ocp_if.sv
// OCP request/response bundle between the bus master and the slave_ocp target.
interface slave_ocp_if #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32
);
  logic [2:0]              MCmd;
  logic [ADDRESSWIDTH-1:0] MAddr;
  logic [DATAWIDTH-1:0]    MData;
  logic                    MDataValid;
  logic                    MDataLast;
  logic                    MRespAccept;
  logic                    SCmdAccept;
  logic [1:0]              SResp;
  logic [DATAWIDTH-1:0]    SData;
  logic                    SRespLast;

  modport master (
    output MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept,
    input  SCmdAccept, SResp, SData, SRespLast
  );

  modport slave (
    input  MCmd, MAddr, MData, MDataValid, MDataLast, MRespAccept,
    output SCmdAccept, SResp, SData, SRespLast
  );
endinterface

// File: rtl/slave_ocp.sv
// OCP target: single write, single read and 1-4 beat burst write into a
// DEPTH-word register file; all bus outputs are registered.
module slave_ocp #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int DEPTH        = 16,
  parameter int RD_LATENCY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  slave_ocp_if.slave ocp
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ACK, S_RD_ACC, S_RD_WAIT, S_BURST, S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic                   scmd_accept_q, scmd_accept_d;
  logic [1:0]             sresp_q, sresp_d;
  logic [DATAWIDTH-1:0]   sdata_q, sdata_d;
  logic                   sresp_last_q, sresp_last_d;
  logic [2:0]             beat_cnt_q, beat_cnt_d;
  logic [2:0]             burst_len_q, burst_len_d;
  logic                   burst_err_q, burst_err_d;
  logic [2:0]             lat_cnt_q, lat_cnt_d;
  logic [IW-1:0]          rd_idx_q, rd_idx_d;
  logic                   rd_ok_q, rd_ok_d;

  logic [DATAWIDTH-1:0]   mem_q [DEPTH];
  logic                   mem_we;

  logic                   addr_ok;
  logic [IW-1:0]          addr_idx;
  logic [2:0]             cmd_len;
  logic [2:0]             next_beat;
  logic                   beat_capture;
  logic                   beat_final;
  logic                   beat_err;

  always_comb begin
    addr_ok      = ocp.MAddr < ADDRESSWIDTH'(DEPTH);
    addr_idx     = ocp.MAddr[IW-1:0];
    cmd_len      = {1'b0, ocp.MCmd[1:0]} + 3'd1;
    next_beat    = (beat_cnt_q == 3'd4) ? 3'd4 : beat_cnt_q + 3'd1;
    beat_capture = ocp.MDataValid && !scmd_accept_q;
    beat_final   = next_beat == burst_len_q;
    beat_err     = burst_err_q || !addr_ok || (ocp.MDataLast != beat_final);
  end

  always_comb begin
    state_d       = state_q;
    scmd_accept_d = 1'b0;
    sresp_d       = sresp_q;
    sdata_d       = sdata_q;
    sresp_last_d  = sresp_last_q;
    beat_cnt_d    = beat_cnt_q;
    burst_len_d   = burst_len_q;
    burst_err_d   = burst_err_q;
    lat_cnt_d     = lat_cnt_q;
    rd_idx_d      = rd_idx_q;
    rd_ok_d       = rd_ok_q;
    mem_we        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sresp_d      = RESP_NULL;
        sresp_last_d = 1'b0;
        sdata_d      = '0;
        if (ocp.MCmd == 3'b001 && ocp.MDataValid) begin
          mem_we        = addr_ok;
          state_d       = S_WR_ACK;
          scmd_accept_d = 1'b1;
          sresp_d       = addr_ok ? RESP_DVA : RESP_ERR;
          sresp_last_d  = 1'b1;
        end else if (ocp.MCmd == 3'b010) begin
          rd_idx_d      = addr_idx;
          rd_ok_d       = addr_ok;
          state_d       = S_RD_ACC;
          scmd_accept_d = 1'b1;
          if (RD_LATENCY == 0) begin
            sresp_d      = addr_ok ? RESP_DVA : RESP_ERR;
            sdata_d      = addr_ok ? mem_q[addr_idx] : '0;
            sresp_last_d = 1'b1;
          end
        end else if (ocp.MCmd[2] && ocp.MDataValid) begin
          mem_we        = addr_ok;
          scmd_accept_d = 1'b1;
          // A one-beat burst, or an early MDataLast on beat 1, closes immediately.
          if (cmd_len == 3'd1 || ocp.MDataLast) begin
            state_d      = S_WR_ACK;
            sresp_last_d = 1'b1;
            sresp_d      = (!addr_ok || (ocp.MDataLast != (cmd_len == 3'd1)))
                           ? RESP_ERR : RESP_DVA;
          end else begin
            state_d     = S_BURST;
            beat_cnt_d  = 3'd1;
            burst_len_d = cmd_len;
            burst_err_d = !addr_ok;
          end
        end
      end

      S_WR_ACK: state_d = S_RESP;

      S_RD_ACC: begin
        if (RD_LATENCY == 0) begin
          state_d = S_RESP;
        end else begin
          state_d   = S_RD_WAIT;
          lat_cnt_d = 3'd1;
        end
      end

      S_RD_WAIT: begin
        if (lat_cnt_q == 3'(RD_LATENCY)) begin
          state_d      = S_RESP;
          lat_cnt_d    = '0;
          sresp_d      = rd_ok_q ? RESP_DVA : RESP_ERR;
          sdata_d      = rd_ok_q ? mem_q[rd_idx_q] : '0;
          sresp_last_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end

      S_BURST: begin
        if (beat_capture) begin
          mem_we        = addr_ok;
          scmd_accept_d = 1'b1;
          // The final beat's accept pulse is issued from WR_ACK alongside the response.
          if (beat_final || ocp.MDataLast) begin
            state_d      = S_WR_ACK;
            beat_cnt_d   = '0;
            burst_err_d  = 1'b0;
            sresp_d      = beat_err ? RESP_ERR : RESP_DVA;
            sdata_d      = '0;
            sresp_last_d = 1'b1;
          end else begin
            beat_cnt_d  = next_beat;
            burst_err_d = beat_err;
          end
        end
      end

      S_RESP: begin
        if (ocp.MRespAccept) begin
          state_d      = S_IDLE;
          sresp_d      = RESP_NULL;
          sdata_d      = '0;
          sresp_last_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      scmd_accept_q <= 1'b0;
      sresp_q       <= RESP_NULL;
      sdata_q       <= '0;
      sresp_last_q  <= 1'b0;
      beat_cnt_q    <= '0;
      burst_len_q   <= '0;
      burst_err_q   <= 1'b0;
      lat_cnt_q     <= '0;
      rd_idx_q      <= '0;
      rd_ok_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      scmd_accept_q <= scmd_accept_d;
      sresp_q       <= sresp_d;
      sdata_q       <= sdata_d;
      sresp_last_q  <= sresp_last_d;
      beat_cnt_q    <= beat_cnt_d;
      burst_len_q   <= burst_len_d;
      burst_err_q   <= burst_err_d;
      lat_cnt_q     <= lat_cnt_d;
      rd_idx_q      <= rd_idx_d;
      rd_ok_q       <= rd_ok_d;
    end
  end

  // Storage is deliberately left out of reset; rst only blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[addr_idx] <= ocp.MData;
    end
  end

  assign ocp.SCmdAccept = scmd_accept_q;
  assign ocp.SResp      = sresp_q;
  assign ocp.SData      = sdata_q;
  assign ocp.SRespLast  = sresp_last_q;
endmodule

// File: tb/tb_slave_ocp.sv
// Scoreboard bench for slave_ocp: stimulus queues expected accepts/responses,
// a negedge monitor pops and compares them as the target presents them.
module tb_slave_ocp;
  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] DVA = 2'b01;
  localparam logic [1:0] ERR = 2'b11;

  typedef struct {
    logic [1:0] resp;
    logic [7:0] data;
    logic       chk_data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] acc_q [$];
  rsp_t       rsp_q [$];

  slave_ocp_if #(.DATAWIDTH(8), .ADDRESSWIDTH(32)) bus ();

  slave_ocp #(
    .DATAWIDTH(8), .ADDRESSWIDTH(32), .DEPTH(16), .RD_LATENCY(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ocp (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor
  rsp_t cur;
  logic cur_active = 1'b0;
  logic acc_seen   = 1'b0;
  logic [1:0] exp_acc;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.SCmdAccept) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_accept", {31'd0, bus.SCmdAccept}, 32'd0);
        end else begin
          exp_acc = acc_q.pop_front();
          chk("accept_sresp", {30'd0, bus.SResp}, {30'd0, exp_acc});
        end
      end
      if (bus.SResp != NUL) begin
        if (!cur_active) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_resp", {30'd0, bus.SResp}, 32'd0);
          end else begin
            cur        = rsp_q.pop_front();
            cur_active = 1'b1;
            acc_seen   = 1'b0;
          end
        end
        if (cur_active) begin
          chk("sresp", {30'd0, bus.SResp}, {30'd0, cur.resp});
          chk("sresp_last", {31'd0, bus.SRespLast}, 32'd1);
          if (cur.chk_data) chk("sdata", {24'd0, bus.SData}, {24'd0, cur.data});
          if (bus.MRespAccept) acc_seen = 1'b1;
        end
      end else if (cur_active) begin
        chk("resp_dropped_before_accept", {31'd0, acc_seen}, 32'd1);
        cur_active = 1'b0;
      end
    end
  end

  task automatic drive(input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [7:0] data, input logic valid, input logic last);
    bus.MCmd       = cmd;
    bus.MAddr      = addr;
    bus.MData      = data;
    bus.MDataValid = valid;
    bus.MDataLast  = last;
  endtask

  task automatic idle();
    drive(3'b000, 32'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_accept(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.SCmdAccept) got = 1'b1;
    end
    if (!got) chk({"timeout_accept_", name}, {31'd0, got}, 32'd1);
  endtask

  // Master: hold the response for `hold` cycles, then accept until it clears.
  task automatic wait_resp(input int hold);
    logic got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (bus.SResp != NUL) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk("timeout_resp", {31'd0, got}, 32'd1);
    repeat (hold) begin @(posedge clk); #1; end
    bus.MRespAccept = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.SResp == NUL) got = 1'b1;
    end
    if (!got) chk("timeout_resp_clear", {31'd0, got}, 32'd1);
    bus.MRespAccept = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] data, input logic [1:0] exp);
    acc_q.push_back(exp);
    rsp_q.push_back('{resp: exp, data: 8'h00, chk_data: 1'b0});
    @(posedge clk); #1;
    drive(3'b001, addr, data, 1'b1, 1'b0);
    @(posedge clk); #1;
    idle();
    wait_resp(0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] exp,
                         input logic [7:0] data, input int hold);
    acc_q.push_back(NUL);
    rsp_q.push_back('{resp: exp, data: data, chk_data: 1'b1});
    @(posedge clk); #1;
    drive(3'b010, addr, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    wait_resp(hold);
  endtask

  // dpk[7:0] is beat 1; beats past ncap are offered but must not be taken.
  task automatic do_burst(input logic [2:0] cmd, input logic [31:0] base, input logic [31:0] dpk,
                          input int nbeats, input int last_beat, input int ncap,
                          input logic [1:0] exp);
    for (int i = 0; i < ncap - 1; i++) acc_q.push_back(NUL);
    acc_q.push_back(exp);
    rsp_q.push_back('{resp: exp, data: 8'h00, chk_data: 1'b0});
    @(posedge clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      drive(cmd, base + 32'(i), dpk[8*i +: 8], 1'b1, (i + 1) == last_beat);
      if (i < ncap) wait_accept("burst_beat");
      else repeat (3) begin @(posedge clk); #1; end
    end
    idle();
    wait_resp(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    bus.MRespAccept = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_scmdaccept", {31'd0, bus.SCmdAccept}, 32'd0);
    chk("reset_sresp",      {30'd0, bus.SResp},      32'd0);
    chk("reset_sdata",      {24'd0, bus.SData},      32'd0);
    chk("reset_sresplast",  {31'd0, bus.SRespLast},  32'd0);
    rst = 1'b0;

    // Single write then back-to-back read with a stalled master
    do_write(32'd5, 8'hA5, DVA);
    do_read(32'd5, DVA, 8'hA5, 3);

    // Full 4-beat burst and read-back
    do_burst(3'b111, 32'd8, 32'h44332211, 4, 4, 4, DVA);
    do_read(32'd8,  DVA, 8'h11, 0);
    do_read(32'd9,  DVA, 8'h22, 0);
    do_read(32'd10, DVA, 8'h33, 0);
    do_read(32'd11, DVA, 8'h44, 0);

    // Address boundary: 15 valid, 16 aliases index 0 but must not write
    do_write(32'd15, 8'hF0, DVA);
    do_read(32'd15, DVA, 8'hF0, 0);
    do_write(32'd0, 8'h5A, DVA);
    do_write(32'd16, 8'h77, ERR);
    do_read(32'd20, ERR, 8'h00, 0);
    do_read(32'd0, DVA, 8'h5A, 0);

    // Early MDataLast on beat 2 of a 3-beat burst; beat 3 is never taken
    do_write(32'd14, 8'hEE, DVA);
    do_burst(3'b110, 32'd12, 32'h00776655, 3, 2, 2, ERR);
    do_read(32'd12, DVA, 8'h55, 0);
    do_read(32'd13, DVA, 8'h66, 0);
    do_read(32'd14, DVA, 8'hEE, 0);

    // Missing MDataLast on the final beat of a 2-beat burst
    do_burst(3'b101, 32'd2, 32'h0000BBAA, 2, 0, 2, ERR);
    do_read(32'd3, DVA, 8'hBB, 0);

    // Reserved command and write without MDataValid: no accept expected
    @(posedge clk); #1;
    drive(3'b011, 32'd1, 8'h99, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(3'b001, 32'd1, 8'h99, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("no_accept_sresp", {30'd0, bus.SResp}, 32'd0);
    idle();

    // Reset during RD_WAIT aborts the read
    acc_q.push_back(NUL);
    @(posedge clk); #1;
    drive(3'b010, 32'd5, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort_sresp",      {30'd0, bus.SResp},      32'd0);
    chk("rst_abort_scmdaccept", {31'd0, bus.SCmdAccept}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("no_late_dva", {30'd0, bus.SResp}, 32'd0);
    do_read(32'd5, DVA, 8'hA5, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("accepts_drained",   32'(acc_q.size()), 32'd0);
    chk("responses_drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
